// File: rtl/cass_player.sv
// Biphase (700 baud) cassette playback generator for the ABC80 core: FIFO-buffered byte stream in, CASS_IN-compatible waveform out.
// Optional feature: define CASS_PLAYER_MOTOR_EN to pause playback while the cassette relay (MOTOR) is off.
module cass_player #(
  parameter int CLK_HZ        = 12_000_000,
  parameter int BAUD          = 700,
  parameter int FIFO_AW       = 4,
  parameter int LEADER_BYTES  = 32,
  parameter int TRAILER_BYTES = 2
) (
  input  logic       CLK12,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  input  logic       DIN_LAST,
  output logic       DIN_READY,
  input  logic       MOTOR,
  output logic       CASS_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       UNDERRUN
);

  localparam int CELL      = CLK_HZ / BAUD;
  localparam int HALF      = CELL / 2;
  localparam int CW        = $clog2(CELL);
  localparam int DEPTH     = 2 ** FIFO_AW;
  localparam int BYTES_MAX = (LEADER_BYTES > TRAILER_BYTES) ? LEADER_BYTES : TRAILER_BYTES;
  localparam int BW        = $clog2(BYTES_MAX + 1);

  localparam logic [CW-1:0]      CNT_LAST   = CW'(CELL - 1);
  localparam logic [CW-1:0]      CNT_MID    = CW'(HALF - 1);
  localparam logic [BW-1:0]      LEAD_LAST  = BW'(LEADER_BYTES - 1);
  localparam logic [BW-1:0]      TRAIL_LAST = BW'(TRAILER_BYTES - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, LEADER, DATA, TRAILER} state_t;

  state_t state, state_next;

  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_next;
  logic [8:0]         head;

  logic          start_q;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [7:0]    shreg;
  logic          last_q;
  logic          stall;

  logic run, go, adv, cell_end, byte_end, want_pop, fifo_empty, pop, stall_set, wr, done_next;

`ifdef CASS_PLAYER_MOTOR_EN
  assign run = MOTOR;
`else
  logic unused_motor;
  assign run          = 1'b1;
  assign unused_motor = MOTOR;
`endif

  assign wr         = DIN_VALID && DIN_READY;
  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign go         = (state == IDLE) && start_q;
  assign adv        = (state != IDLE) && run && !stall;
  assign cell_end   = adv && (cnt == CNT_LAST);
  assign byte_end   = cell_end && (bit_cnt == 3'd7);
  // A byte is fetched after the last leader byte, after every non-final data byte, and on every stalled cycle.
  assign want_pop   = run && ((state == DATA && stall) ||
                      (byte_end && ((state == LEADER && byte_cnt == LEAD_LAST) ||
                                    (state == DATA && !last_q))));
  assign pop        = want_pop && !fifo_empty;
  assign stall_set  = want_pop && fifo_empty;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:    if (go) state_next = LEADER;
      LEADER:  if (byte_end && byte_cnt == LEAD_LAST) state_next = DATA;
      DATA:    if (byte_end && last_q) state_next = TRAILER;
      TRAILER: if (byte_end && byte_cnt == TRAIL_LAST) begin
                 state_next = IDLE;
                 done_next  = 1'b1;
               end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({wr, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge CLK12) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: storage is left unreset; the pointers and count define what is valid, so a reset flushes it.
  always_ff @(posedge CLK12) begin
    if (wr) mem[wr_ptr] <= {DIN_LAST, DIN};
  end

  always_ff @(posedge CLK12) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      DIN_READY <= 1'b1;
      start_q   <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      last_q    <= 1'b0;
      stall     <= 1'b0;
      CASS_OUT  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      start_q   <= START && (state == IDLE) && run;
      BUSY      <= (state_next != IDLE);
      DONE      <= done_next;
      count     <= count_next;
      DIN_READY <= (count_next != FULL_CNT);
      if (wr)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;

      if (go) begin
        cnt      <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        shreg    <= '0;
        last_q   <= 1'b0;
        stall    <= 1'b0;
        UNDERRUN <= 1'b0;
        CASS_OUT <= ~CASS_OUT;
      end else if (pop) begin
        shreg    <= head[7:0];
        last_q   <= head[8];
        cnt      <= '0;
        bit_cnt  <= '0;
        stall    <= 1'b0;
        CASS_OUT <= ~CASS_OUT;
      end else if (stall_set) begin
        // Counter and line level hold until the FIFO has data again.
        stall    <= 1'b1;
        UNDERRUN <= 1'b1;
      end else if (cell_end) begin
        cnt     <= '0;
        bit_cnt <= bit_cnt + 3'd1;
        if (state_next != IDLE) CASS_OUT <= ~CASS_OUT;
        if (byte_end) begin
          shreg    <= '0;
          byte_cnt <= (state_next != state) ? '0 : byte_cnt + BW'(1);
        end
      end else if (adv) begin
        cnt <= cnt + CW'(1);
        if (cnt == CNT_MID && shreg[bit_cnt]) CASS_OUT <= ~CASS_OUT;
      end
    end
  end

endmodule
